video_timing: RTL and testbench

Raster timing generator and pixel output stage that drives the pixel generators. It scans the full frame (active area plus blanking), presents the current active-area coordinate x/y to a combinational pixel generator, and samples that generator's r/g/b in the same cycle. It outputs registered r/g/b aligned with hsync/vsync/de, ready for the DVI/VGA serializer or DAC.

---
 rtl/video_timing_if.sv | 37 +++
 rtl/video_timing.sv | 129 ++++++++++++
 tb/tb_video_timing.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/video_timing_if.sv
// ============================================================================
// Module : video_timing_if
// Brief  : Pixel-generator / output-stage bundle for video_timing.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface video_timing_if #(
  parameter int X_WIDTH = 10,
  parameter int Y_WIDTH = 9
);
  logic [X_WIDTH-1:0] x;
  logic [Y_WIDTH-1:0] y;
  logic [7:0]         pix_r;
  logic [7:0]         pix_g;
  logic [7:0]         pix_b;
  logic [7:0]         r;
  logic [7:0]         g;
  logic [7:0]         b;
  logic               hsync;
  logic               vsync;
  logic               de;
  logic               frame_start;

  // Timing generator side: publishes coordinates, consumes pixel colour.
  modport master (
    output x, y, r, g, b, hsync, vsync, de, frame_start,
    input  pix_r, pix_g, pix_b
  );

  modport slave (
    input  x, y, r, g, b, hsync, vsync, de, frame_start,
    output pix_r, pix_g, pix_b
  );
endinterface

`default_nettype wire

// File: rtl/video_timing.sv
// ============================================================================
// Module : video_timing
// Brief  : Raster timing generator with one-register pixel output stage.
//          Optional macro VIDEO_TIMING_BLANK_ZERO_EN forces black in blanking.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module video_timing #(
  parameter int HOR_ACTIVE_PIXELS = 640,
  parameter int HOR_FRONT_PORCH   = 16,
  parameter int HOR_SYNC_PULSE    = 96,
  parameter int HOR_BACK_PORCH    = 48,
  parameter int VER_ACTIVE_PIXELS = 480,
  parameter int VER_FRONT_PORCH   = 10,
  parameter int VER_SYNC_PULSE    = 2,
  parameter int VER_BACK_PORCH    = 33,
  parameter int HSYNC_ACTIVE_HIGH = 0,
  parameter int VSYNC_ACTIVE_HIGH = 0
) (
  input  wire logic       clk,
  input  wire logic       rst,
  video_timing_if.master  vid
);

  localparam int H_TOTAL = HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH + HOR_SYNC_PULSE + HOR_BACK_PORCH;
  localparam int V_TOTAL = VER_ACTIVE_PIXELS + VER_FRONT_PORCH + VER_SYNC_PULSE + VER_BACK_PORCH;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);
  localparam int X_W     = $clog2(HOR_ACTIVE_PIXELS);
  localparam int Y_W     = $clog2(VER_ACTIVE_PIXELS);

  // Comparisons are made one bit wider so a sync end equal to the total still fits.
  localparam logic [H_W-1:0] c_h_last     = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0] c_v_last     = V_W'(V_TOTAL - 1);
  localparam logic [H_W:0]   c_h_act      = (H_W+1)'(HOR_ACTIVE_PIXELS);
  localparam logic [V_W:0]   c_v_act      = (V_W+1)'(VER_ACTIVE_PIXELS);
  localparam logic [H_W:0]   c_hs_start   = (H_W+1)'(HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH);
  localparam logic [H_W:0]   c_hs_end     = (H_W+1)'(HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH + HOR_SYNC_PULSE);
  localparam logic [V_W:0]   c_vs_start   = (V_W+1)'(VER_ACTIVE_PIXELS + VER_FRONT_PORCH);
  localparam logic [V_W:0]   c_vs_end     = (V_W+1)'(VER_ACTIVE_PIXELS + VER_FRONT_PORCH + VER_SYNC_PULSE);
  localparam logic           c_hsync_idle = (HSYNC_ACTIVE_HIGH == 0);
  localparam logic           c_vsync_idle = (VSYNC_ACTIVE_HIGH == 0);

  logic [H_W-1:0] h_cnt_q, h_cnt_d;
  logic [V_W-1:0] v_cnt_q, v_cnt_d;
  logic [7:0]     r_q, r_d;
  logic [7:0]     g_q, g_d;
  logic [7:0]     b_q, b_d;
  logic           de_q, de_d;
  logic           hsync_q, hsync_d;
  logic           vsync_q, vsync_d;
  logic           frame_start_q, frame_start_d;

  logic [H_W:0]   h_ext;
  logic [V_W:0]   v_ext;
  logic           active;
  logic           hsync_raw;
  logic           vsync_raw;

  assign h_ext     = {1'b0, h_cnt_q};
  assign v_ext     = {1'b0, v_cnt_q};
  assign active    = (h_ext < c_h_act) && (v_ext < c_v_act);
  assign hsync_raw = (h_ext >= c_hs_start) && (h_ext < c_hs_end);
  assign vsync_raw = (v_ext >= c_vs_start) && (v_ext < c_vs_end);

  always_comb begin
    h_cnt_d = h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == c_h_last) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == c_v_last) ? '0 : v_cnt_q + 1'b1;
    end
  end

  always_comb begin
    de_d          = active;
    hsync_d       = hsync_raw ^ c_hsync_idle;
    vsync_d       = vsync_raw ^ c_vsync_idle;
    frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
`ifdef VIDEO_TIMING_BLANK_ZERO_EN
    r_d = active ? vid.pix_r : 8'd0;
    g_d = active ? vid.pix_g : 8'd0;
    b_d = active ? vid.pix_b : 8'd0;
`else
    r_d = vid.pix_r;
    g_d = vid.pix_g;
    b_d = vid.pix_b;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      r_q           <= 8'd0;
      g_q           <= 8'd0;
      b_q           <= 8'd0;
      de_q          <= 1'b0;
      hsync_q       <= c_hsync_idle;
      vsync_q       <= c_vsync_idle;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
      de_q          <= de_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Coordinates are only meaningful while active, so truncation is harmless.
  assign vid.x           = active ? h_cnt_q[X_W-1:0] : '0;
  assign vid.y           = active ? v_cnt_q[Y_W-1:0] : '0;
  assign vid.r           = r_q;
  assign vid.g           = g_q;
  assign vid.b           = b_q;
  assign vid.de          = de_q;
  assign vid.hsync       = hsync_q;
  assign vid.vsync       = vsync_q;
  assign vid.frame_start = frame_start_q;

endmodule

`default_nettype wire

// File: tb/tb_video_timing.sv
// ============================================================================
// Module : tb_video_timing
// Brief  : Directed self-checking bench; small raster, both sync polarities.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_video_timing;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   fs_cnt   = 0;
  int   de_cnt   = 0;

  always #5 clk = ~clk;

  video_timing_if #(.X_WIDTH(2), .Y_WIDTH(2)) vid_a ();
  video_timing_if #(.X_WIDTH(2), .Y_WIDTH(2)) vid_b ();

  // Pixel generator for the low-polarity unit: {x, y, x^y}; the other is tied white.
  assign vid_a.pix_r = {6'd0, vid_a.x};
  assign vid_a.pix_g = {6'd0, vid_a.y};
  assign vid_a.pix_b = {6'd0, vid_a.x ^ vid_a.y};
  assign vid_b.pix_r = 8'hFF;
  assign vid_b.pix_g = 8'hFF;
  assign vid_b.pix_b = 8'hFF;

  video_timing #(
    .HOR_ACTIVE_PIXELS(4), .HOR_FRONT_PORCH(1), .HOR_SYNC_PULSE(2), .HOR_BACK_PORCH(1),
    .VER_ACTIVE_PIXELS(3), .VER_FRONT_PORCH(1), .VER_SYNC_PULSE(1), .VER_BACK_PORCH(1),
    .HSYNC_ACTIVE_HIGH(0), .VSYNC_ACTIVE_HIGH(0)
  ) u_dut_a (
    .clk(clk),
    .rst(rst),
    .vid(vid_a)
  );

  video_timing #(
    .HOR_ACTIVE_PIXELS(4), .HOR_FRONT_PORCH(1), .HOR_SYNC_PULSE(2), .HOR_BACK_PORCH(1),
    .VER_ACTIVE_PIXELS(3), .VER_FRONT_PORCH(1), .VER_SYNC_PULSE(1), .VER_BACK_PORCH(1),
    .HSYNC_ACTIVE_HIGH(1), .VSYNC_ACTIVE_HIGH(1)
  ) u_dut_b (
    .clk(clk),
    .rst(rst),
    .vid(vid_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string where);
    chk({where, " a.de"},    32'(vid_a.de),          32'd0);
    chk({where, " a.r"},     32'(vid_a.r),           32'd0);
    chk({where, " a.g"},     32'(vid_a.g),           32'd0);
    chk({where, " a.b"},     32'(vid_a.b),           32'd0);
    chk({where, " a.hsync"}, 32'(vid_a.hsync),       32'd1);
    chk({where, " a.vsync"}, 32'(vid_a.vsync),       32'd1);
    chk({where, " a.fs"},    32'(vid_a.frame_start), 32'd0);
    chk({where, " b.hsync"}, 32'(vid_b.hsync),       32'd0);
    chk({where, " b.vsync"}, 32'(vid_b.vsync),       32'd0);
    chk({where, " b.de"},    32'(vid_b.de),          32'd0);
    chk({where, " b.r"},     32'(vid_b.r),           32'd0);
  endtask

  // Outputs seen after this edge reflect raster position n (8 clk/line, 6 lines/frame).
  task automatic check_pos(input int n);
    int   h;
    int   v;
    logic act;
    logic hs_on;
    logic vs_on;
    logic [7:0] b_white;
    string t;
    h     = n % 8;
    v     = (n / 8) % 6;
    act   = (h < 4) && (v < 3);
    hs_on = (h == 5) || (h == 6);
    vs_on = (v == 4);
`ifdef VIDEO_TIMING_BLANK_ZERO_EN
    b_white = act ? 8'hFF : 8'h00;
`else
    b_white = 8'hFF;
`endif
    t = $sformatf("n=%0d h=%0d v=%0d", n, h, v);
    chk({t, " a.de"},    32'(vid_a.de),          32'(act));
    chk({t, " a.hsync"}, 32'(vid_a.hsync),       32'(!hs_on));
    chk({t, " a.vsync"}, 32'(vid_a.vsync),       32'(!vs_on));
    chk({t, " a.fs"},    32'(vid_a.frame_start), 32'((h == 0) && (v == 0)));
    chk({t, " a.r"},     32'(vid_a.r),           act ? 32'(h) : 32'd0);
    chk({t, " a.g"},     32'(vid_a.g),           act ? 32'(v) : 32'd0);
    chk({t, " a.b"},     32'(vid_a.b),           act ? 32'(h ^ v) : 32'd0);
    chk({t, " b.de"},    32'(vid_b.de),          32'(act));
    chk({t, " b.hsync"}, 32'(vid_b.hsync),       32'(hs_on));
    chk({t, " b.vsync"}, 32'(vid_b.vsync),       32'(vs_on));
    chk({t, " b.r"},     32'(vid_b.r),           32'(b_white));
    chk({t, " b.g"},     32'(vid_b.g),           32'(b_white));
    chk({t, " b.b"},     32'(vid_b.b),           32'(b_white));
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    check_reset("reset");
    rst = 1'b0;

    // Counters are at (0,0) now; edge k shows position k-1.
    for (int k = 1; k <= 106; k++) begin
      tick();
      check_pos(k - 1);
      if (k <= 96) begin
        if (vid_a.frame_start) fs_cnt++;
        if (vid_a.de) de_cnt++;
      end
      if (k - 1 == 19) begin
        chk("pixel(3,2) r", 32'(vid_a.r), 32'd3);
        chk("pixel(3,2) g", 32'(vid_a.g), 32'd2);
        chk("pixel(3,2) b", 32'(vid_a.b), 32'd1);
      end
    end
    chk("frame_start per 96 clk", 32'(fs_cnt), 32'd2);
    chk("de cycles per 96 clk",   32'(de_cnt), 32'd24);

    // Counters now sit at h=2, v=1 of the third frame: abort it.
    rst = 1'b1;
    tick();
    check_reset("midframe");
    rst = 1'b0;
    tick();
    chk("post-reset de", 32'(vid_a.de),          32'd1);
    chk("post-reset fs", 32'(vid_a.frame_start), 32'd1);
    chk("post-reset r",  32'(vid_a.r),           32'd0);
    check_pos(0);
    for (int k = 2; k <= 60; k++) begin
      tick();
      check_pos(k - 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
